iencoder: RTL and testbench

IENCODER -- requirements
Module: iencoder

---
 rtl/iencoder.sv | 267 ++++++++++++++++++++++++++
 tb/tb_iencoder.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iencoder.sv
// iencoder: RV32I instruction encoder feeding a small output FIFO.
// Illegal requests push a zero word with the error flag set.
`ifndef INST_TYPE_WIDTH
`define INST_TYPE_WIDTH 4
`endif
`ifndef FUNCT_WIDTH
`define FUNCT_WIDTH 5
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 5
`endif
`ifndef IMM_WIDTH
`define IMM_WIDTH 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef INST_TYPE_LUI
`define INST_TYPE_LUI     4'd0
`define INST_TYPE_AUIPC   4'd1
`define INST_TYPE_JAL     4'd2
`define INST_TYPE_JALR    4'd3
`define INST_TYPE_BRANCH  4'd4
`define INST_TYPE_LOAD    4'd5
`define INST_TYPE_STORE   4'd6
`define INST_TYPE_INT_IMM 4'd7
`define INST_TYPE_INT_REG 4'd8
`define INST_TYPE_FENCE   4'd9
`endif
`ifndef FUNCT_ADD
`define FUNCT_ADD         5'd0
`define FUNCT_SUB         5'd1
`define FUNCT_SLL         5'd2
`define FUNCT_SLT         5'd3
`define FUNCT_SLTU        5'd4
`define FUNCT_XOR         5'd5
`define FUNCT_SRL         5'd6
`define FUNCT_SRA         5'd7
`define FUNCT_OR          5'd8
`define FUNCT_AND         5'd9
`define FUNCT_EQ          5'd10
`define FUNCT_NEQ         5'd11
`define FUNCT_LT          5'd12
`define FUNCT_GTE         5'd13
`define FUNCT_LTU         5'd14
`define FUNCT_GTEU        5'd15
`define FUNCT_MEM_BYTE    5'd16
`define FUNCT_MEM_HWORD   5'd17
`define FUNCT_MEM_WORD    5'd18
`define FUNCT_MEM_BYTEU   5'd19
`define FUNCT_MEM_HWORDU  5'd20
`endif

module iencoder #(
  parameter int OUT_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [`INST_TYPE_WIDTH-1:0] inst_type,
  input  logic [`FUNCT_WIDTH-1:0]     funct,
  input  logic [`REG_WIDTH-1:0]       rd,
  input  logic [`REG_WIDTH-1:0]       rs1,
  input  logic [`REG_WIDTH-1:0]       rs2,
  input  logic [`IMM_WIDTH-1:0]       imm,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [`INST_WIDTH-1:0]      out_inst,
  output logic                        out_err,
  output logic [7:0]                  err_count
);

  localparam int PW = $clog2(OUT_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(OUT_DEPTH);

  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] OP_REG   = 7'h33;

  logic [2:0] w_alu_f3;
  logic       w_alu_alt;
  logic       w_alu_ok;
  logic       w_is_shift;
  logic [2:0] w_br_f3;
  logic       w_br_ok;
  logic [2:0] w_mem_f3;
  logic       w_ld_ok;
  logic       w_st_ok;
  logic       w_i12_ok;
  logic       w_b13_ok;
  logic       w_j21_ok;
  logic       w_u_ok;
  logic       w_sh_ok;
  logic [31:0] w_inst;
  logic       w_ok;
  logic       w_push;
  logic       w_pop;

  logic [`INST_WIDTH-1:0] r_inst [OUT_DEPTH];
  logic                   r_err  [OUT_DEPTH];
  logic [PW-1:0]          r_wptr;
  logic [PW-1:0]          r_rptr;
  logic [CW-1:0]          r_count;
  logic [7:0]             r_err_cnt;

  always_comb begin
    w_alu_f3   = 3'd0;
    w_alu_alt  = 1'b0;
    w_alu_ok   = 1'b1;
    w_is_shift = 1'b0;
    case (funct)
      `FUNCT_ADD:  w_alu_f3 = 3'd0;
      `FUNCT_SUB:  w_alu_alt = 1'b1;
      `FUNCT_SLL:  begin w_alu_f3 = 3'd1; w_is_shift = 1'b1; end
      `FUNCT_SLT:  w_alu_f3 = 3'd2;
      `FUNCT_SLTU: w_alu_f3 = 3'd3;
      `FUNCT_XOR:  w_alu_f3 = 3'd4;
      `FUNCT_SRL:  begin w_alu_f3 = 3'd5; w_is_shift = 1'b1; end
      `FUNCT_SRA:  begin
        w_alu_f3   = 3'd5;
        w_alu_alt  = 1'b1;
        w_is_shift = 1'b1;
      end
      `FUNCT_OR:   w_alu_f3 = 3'd6;
      `FUNCT_AND:  w_alu_f3 = 3'd7;
      default:     w_alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_br_f3 = 3'd0;
    w_br_ok = 1'b1;
    case (funct)
      `FUNCT_EQ:   w_br_f3 = 3'd0;
      `FUNCT_NEQ:  w_br_f3 = 3'd1;
      `FUNCT_LT:   w_br_f3 = 3'd4;
      `FUNCT_GTE:  w_br_f3 = 3'd5;
      `FUNCT_LTU:  w_br_f3 = 3'd6;
      `FUNCT_GTEU: w_br_f3 = 3'd7;
      default:     w_br_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_mem_f3 = 3'd0;
    w_ld_ok  = 1'b1;
    w_st_ok  = 1'b1;
    case (funct)
      `FUNCT_MEM_BYTE:   w_mem_f3 = 3'd0;
      `FUNCT_MEM_HWORD:  w_mem_f3 = 3'd1;
      `FUNCT_MEM_WORD:   w_mem_f3 = 3'd2;
      `FUNCT_MEM_BYTEU:  begin w_mem_f3 = 3'd4; w_st_ok = 1'b0; end
      `FUNCT_MEM_HWORDU: begin w_mem_f3 = 3'd5; w_st_ok = 1'b0; end
      default: begin
        w_ld_ok = 1'b0;
        w_st_ok = 1'b0;
      end
    endcase
  end

  // Range checks: upper bits must all replicate the sign bit.
  assign w_i12_ok = (&imm[31:11]) | ~(|imm[31:11]);
  assign w_b13_ok = ~imm[0] & ((&imm[31:12]) | ~(|imm[31:12]));
  assign w_j21_ok = ~imm[0] & ((&imm[31:20]) | ~(|imm[31:20]));
  assign w_u_ok   = ~(|imm[11:0]);
  assign w_sh_ok  = ~(|imm[31:5]);

  always_comb begin
    w_inst = '0;
    w_ok   = 1'b0;
    case (inst_type)
      `INST_TYPE_LUI: begin
        w_ok   = w_u_ok;
        w_inst = {imm[31:12], rd, OP_LUI};
      end
      `INST_TYPE_AUIPC: begin
        w_ok   = w_u_ok;
        w_inst = {imm[31:12], rd, OP_AUIPC};
      end
      `INST_TYPE_JAL: begin
        w_ok   = w_j21_ok;
        w_inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      end
      `INST_TYPE_JALR: begin
        w_ok   = w_i12_ok;
        w_inst = {imm[11:0], rs1, 3'd0, rd, OP_JALR};
      end
      `INST_TYPE_BRANCH: begin
        w_ok   = w_br_ok & w_b13_ok;
        w_inst = {imm[12], imm[10:5], rs2, rs1, w_br_f3,
                  imm[4:1], imm[11], OP_BR};
      end
      `INST_TYPE_LOAD: begin
        w_ok   = w_ld_ok & w_i12_ok;
        w_inst = {imm[11:0], rs1, w_mem_f3, rd, OP_LOAD};
      end
      `INST_TYPE_STORE: begin
        w_ok   = w_st_ok & w_i12_ok;
        w_inst = {imm[11:5], rs2, rs1, w_mem_f3, imm[4:0], OP_STORE};
      end
      `INST_TYPE_INT_IMM: begin
        if (w_is_shift) begin
          w_ok   = w_alu_ok & w_sh_ok;
          w_inst = {1'b0, w_alu_alt, 5'd0, imm[4:0], rs1,
                    w_alu_f3, rd, OP_IMM};
        end else begin
          w_ok   = w_alu_ok & ~w_alu_alt & w_i12_ok;
          w_inst = {imm[11:0], rs1, w_alu_f3, rd, OP_IMM};
        end
      end
      `INST_TYPE_INT_REG: begin
        w_ok   = w_alu_ok;
        w_inst = {1'b0, w_alu_alt, 5'd0, rs2, rs1, w_alu_f3, rd, OP_REG};
      end
      `INST_TYPE_FENCE: begin
        w_ok   = 1'b1;
        w_inst = 32'h0FF0000F;
      end
      default: w_ok = 1'b0;
    endcase
    if (!w_ok) w_inst = '0;
  end

  assign in_ready  = (r_count < DEPTH_C);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign out_inst  = out_valid ? r_inst[r_rptr] : '0;
  assign out_err   = out_valid & r_err[r_rptr];
  assign err_count = r_err_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && !w_ok && r_err_cnt != 8'hFF)
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  // Storage needs no reset: the head is masked by out_valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_inst[r_wptr] <= w_inst;
      r_err[r_wptr]  <= ~w_ok;
    end
  end

endmodule

// File: tb/tb_iencoder.sv
// tb_iencoder: vector table, corner sequences and randomized
// traffic against a behavioural encoder/FIFO model.
module tb_iencoder;

  localparam int DEPTH = 2;

  localparam logic [3:0] T_LUI = 4'd0, T_AUIPC = 4'd1, T_JAL = 4'd2;
  localparam logic [3:0] T_JALR = 4'd3, T_BR = 4'd4, T_LOAD = 4'd5;
  localparam logic [3:0] T_STORE = 4'd6, T_IMM = 4'd7, T_REG = 4'd8;
  localparam logic [3:0] T_FENCE = 4'd9, T_BAD = 4'd12;

  localparam logic [4:0] F_ADD = 5'd0, F_SUB = 5'd1, F_SLL = 5'd2;
  localparam logic [4:0] F_SRL = 5'd6, F_SRA = 5'd7;
  localparam logic [4:0] F_EQ = 5'd10, F_NEQ = 5'd11, F_LT = 5'd12;
  localparam logic [4:0] F_BYTE = 5'd16, F_WORD = 5'd18, F_BYTEU = 5'd19;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  inst_type;
  logic [4:0]  funct;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic [7:0]  err_count;

  int n_chk = 0;
  int n_fail = 0;

  iencoder #(.OUT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .inst_type(inst_type), .funct(funct),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_err(out_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  t;
    logic [4:0]  f;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    in_valid  = 1'b1;
    inst_type = v.t;
    funct     = v.f;
    rd        = v.rd;
    rs1       = v.rs1;
    rs2       = v.rs2;
    imm       = v.imm;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  // Behavioural reference: encoding from field placement and integer ranges.
  function automatic logic [32:0] ref_enc(
    input logic [3:0] t, input logic [4:0] f,
    input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
    input logic [31:0] im);
    int alu_f3[10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    int br_f3[6]   = '{0, 1, 4, 5, 6, 7};
    int mem_f3[5]  = '{0, 1, 2, 4, 5};
    int si;
    bit ok, in12, shf;
    logic [31:0] w, vd, v1, v2, f3;
    si = $signed(im);
    vd = 32'(d);
    v1 = 32'(s1);
    v2 = 32'(s2);
    in12 = (si >= -2048) && (si <= 2047);
    ok = 1'b0;
    w = 32'h0;
    f3 = 32'h0;
    case (t)
      T_LUI, T_AUIPC: begin
        ok = (im % 4096) == 0;
        w = im + (vd << 7) + ((t == T_LUI) ? 32'h37 : 32'h17);
      end
      T_JAL: begin
        ok = (si % 2 == 0) && (si >= -(1 << 20)) && (si < (1 << 20));
        w = {im[20], im[10:1], im[11], im[19:12], d, 7'h6F};
      end
      T_JALR: begin
        ok = in12;
        w = (im << 20) | (v1 << 15) | (vd << 7) | 32'h67;
      end
      T_BR: begin
        ok = (f >= 10) && (f <= 15) && (si % 2 == 0) &&
             (si >= -4096) && (si <= 4095);
        if (ok) f3 = 32'(br_f3[f - 10]);
        w = {im[12], im[10:5], s2, s1, f3[2:0], im[4:1], im[11], 7'h63};
      end
      T_LOAD: begin
        ok = (f >= 16) && (f <= 20) && in12;
        if (ok) f3 = 32'(mem_f3[f - 16]);
        w = (im << 20) | (v1 << 15) | (f3 << 12) | (vd << 7) | 32'h03;
      end
      T_STORE: begin
        ok = (f >= 16) && (f <= 18) && in12;
        if (ok) f3 = 32'(mem_f3[f - 16]);
        w = (((im >> 5) & 32'h7F) << 25) | (v2 << 20) | (v1 << 15) |
            (f3 << 12) | ((im & 32'h1F) << 7) | 32'h23;
      end
      T_IMM: begin
        shf = (f == F_SLL) || (f == F_SRL) || (f == F_SRA);
        if (f <= 9 && f != F_SUB) begin
          f3 = 32'(alu_f3[f]);
          if (shf) begin
            ok = im <= 31;
            w = ((f == F_SRA) ? 32'h40000000 : 32'h0) | (im << 20);
          end else begin
            ok = in12;
            w = im << 20;
          end
          w = w | (v1 << 15) | (f3 << 12) | (vd << 7) | 32'h13;
        end
      end
      T_REG: begin
        ok = f <= 9;
        if (ok) f3 = 32'(alu_f3[f]);
        w = ((f == F_SUB || f == F_SRA) ? 32'h40000000 : 32'h0) |
            (v2 << 20) | (v1 << 15) | (f3 << 12) | (vd << 7) | 32'h33;
      end
      T_FENCE: begin
        ok = 1'b1;
        w = 32'h0FF0000F;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) w = 32'h0;
    return {~ok, w};
  endfunction

  function automatic logic [31:0] rnd_imm();
    int pick[14] = '{2047, 2048, -2048, -2049, 31, 32, 4095, 4096,
                     -4096, -4097, 1048575, 1048576, -1048576, -1048577};
    case ($urandom_range(0, 5))
      0: return 32'($signed($urandom_range(0, 80)) - 40);
      1: return $urandom();
      2: return $urandom() << 12;
      3: return 32'(pick[$urandom_range(0, 13)]);
      4: return 32'($urandom_range(0, 40));
      default: return 32'($urandom_range(0, 2000) * 2) - 32'd2000;
    endcase
  endfunction

  logic [32:0] q[$];
  int m_err;
  int tbl_err;
  int sz;
  logic [32:0] e;

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    inst_type = '0;
    funct = '0;
    rd = '0;
    rs1 = '0;
    rs2 = '0;
    imm = '0;

    tbl.push_back('{T_REG, F_ADD, 5'd3, 5'd1, 5'd2, 32'h0, 32'h002081B3, 1'b0});
    tbl.push_back('{T_IMM, F_ADD, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0});
    tbl.push_back('{T_IMM, F_SRA, 5'd5, 5'd6, 5'd0, 32'd4, 32'h40435293, 1'b0});
    tbl.push_back('{T_FENCE, F_SUB, 5'd7, 5'd7, 5'd7, 32'h5, 32'h0FF0000F, 1'b0});
    tbl.push_back('{T_LUI, F_ADD, 5'd1, 5'd0, 5'd0, 32'h12345000, 32'h123450B7, 1'b0});
    tbl.push_back('{T_LUI, F_ADD, 5'd1, 5'd0, 5'd0, 32'h12345001, 32'h0, 1'b1});
    tbl.push_back('{T_IMM, F_SUB, 5'd1, 5'd2, 5'd0, 32'd1, 32'h0, 1'b1});
    tbl.push_back('{T_STORE, F_BYTEU, 5'd0, 5'd2, 5'd3, 32'd8, 32'h0, 1'b1});
    tbl.push_back('{T_IMM, F_SLL, 5'd1, 5'd2, 5'd0, 32'd32, 32'h0, 1'b1});
    tbl.push_back('{T_IMM, F_ADD, 5'd1, 5'd2, 5'd0, 32'd2048, 32'h0, 1'b1});
    tbl.push_back('{T_REG, F_SUB, 5'd3, 5'd1, 5'd2, 32'h0, 32'h402081B3, 1'b0});
    tbl.push_back('{T_JAL, F_ADD, 5'd1, 5'd0, 5'd0, 32'd2, 32'h002000EF, 1'b0});
    tbl.push_back('{T_JAL, F_ADD, 5'd1, 5'd0, 5'd0, 32'h00100000, 32'h0, 1'b1});
    tbl.push_back('{T_BR, F_NEQ, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 32'hFE209EE3, 1'b0});
    tbl.push_back('{T_STORE, F_WORD, 5'd0, 5'd2, 5'd3, 32'd8, 32'h00312423, 1'b0});
    tbl.push_back('{T_LOAD, F_BYTEU, 5'd5, 5'd1, 5'd0, 32'hFFFFFFFF, 32'hFFF0C283, 1'b0});
    tbl.push_back('{T_JALR, F_SUB, 5'd1, 5'd2, 5'd0, 32'd4, 32'h004100E7, 1'b0});
    tbl.push_back('{T_BAD, F_ADD, 5'd1, 5'd2, 5'd3, 32'h0, 32'h0, 1'b1});
    tbl.push_back('{T_AUIPC, F_ADD, 5'd2, 5'd0, 5'd0, 32'hFFFFF000, 32'hFFFFF117, 1'b0});
    tbl.push_back('{T_BR, F_EQ, 5'd0, 5'd1, 5'd2, 32'd4096, 32'h0, 1'b1});
    tbl.push_back('{T_BR, F_ADD, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0, 1'b1});
    tbl.push_back('{T_LOAD, F_BYTE, 5'd1, 5'd1, 5'd0, 32'hFFFFF7FF, 32'h0, 1'b1});

    // Reset values while rst is held low
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_out_err", 32'(out_err), 32'd0);

    // Vector table; first request lands on the first edge after release
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    tbl_err = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_inst", i), out_inst, tbl[i].inst);
      chk($sformatf("vec%0d_err", i), 32'(out_err), 32'(tbl[i].err));
      if (tbl[i].err) tbl_err++;
      @(negedge clk);
      chk($sformatf("vec%0d_drained", i), 32'(out_valid), 32'd0);
    end
    chk("tbl_err_count", 32'(err_count), 32'(tbl_err));

    // Illegal branch offset then saturation of the error counter
    do_reset();
    out_ready = 1'b1;
    apply('{T_BR, F_EQ, 5'd0, 5'd1, 5'd2, 32'd3, 32'h0, 1'b1});
    @(negedge clk);
    in_valid = 1'b0;
    chk("br_odd_inst", out_inst, 32'h0);
    chk("br_odd_err", 32'(out_err), 32'd1);
    chk("br_odd_cnt", 32'(err_count), 32'd1);
    @(negedge clk);
    apply('{T_BAD, F_ADD, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1});
    repeat (253) @(negedge clk);
    chk("err_cnt_254", 32'(err_count), 32'd254);
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("err_cnt_sat", 32'(err_count), 32'd255);
    @(negedge clk);
    chk("err_cnt_hold", 32'(err_count), 32'd255);

    // Back-pressure with a full FIFO, then push and pop on one edge
    do_reset();
    out_ready = 1'b0;
    apply(tbl[0]);
    @(negedge clk);
    chk("bp_ready1", 32'(in_ready), 32'd1);
    chk("bp_head_a", out_inst, tbl[0].inst);
    apply(tbl[3]);
    @(negedge clk);
    chk("bp_full", 32'(in_ready), 32'd0);
    apply(tbl[4]);
    @(negedge clk);
    chk("bp_held", 32'(in_ready), 32'd0);
    chk("bp_stable_a", out_inst, tbl[0].inst);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_head_b", out_inst, tbl[3].inst);
    chk("bp_ready_again", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pp_valid", 32'(out_valid), 32'd1);
    chk("pp_count1", 32'(in_ready), 32'd1);
    chk("pp_head_c", out_inst, tbl[4].inst);
    @(negedge clk);
    chk("pp_empty", 32'(out_valid), 32'd0);

    // Asynchronous reset between edges with two entries held
    do_reset();
    out_ready = 1'b0;
    apply(tbl[5]);
    @(negedge clk);
    apply(tbl[0]);
    @(negedge clk);
    in_valid = 1'b0;
    chk("ar_pre_valid", 32'(out_valid), 32'd1);
    chk("ar_pre_cnt", 32'(err_count), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_cnt", 32'(err_count), 32'd0);
    chk("ar_ready", 32'(in_ready), 32'd1);
    chk("ar_inst", out_inst, 32'h0);
    chk("ar_err", 32'(out_err), 32'd0);
    #1 rst = 1'b1;

    // Randomized traffic against the queue model
    m_err = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      chk("rnd_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("rnd_ready", 32'(in_ready), 32'(q.size() < DEPTH));
      chk("rnd_err_count", 32'(err_count), 32'(m_err));
      if (q.size() != 0) begin
        chk("rnd_inst", out_inst, q[0][31:0]);
        chk("rnd_err", 32'(out_err), 32'(q[0][32]));
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      inst_type = ($urandom_range(0, 15) == 0) ? 4'd15 :
                  4'($urandom_range(0, 11));
      funct     = 5'($urandom_range(0, 22));
      rd        = 5'($urandom());
      rs1       = 5'($urandom());
      rs2       = 5'($urandom());
      imm       = rnd_imm();
      sz = q.size();
      if (out_ready && sz > 0) void'(q.pop_front());
      if (in_valid && sz < DEPTH) begin
        e = ref_enc(inst_type, funct, rd, rs1, rs2, imm);
        q.push_back(e);
        if (e[32] && m_err < 255) m_err++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
